// File: rtl/sm83_slice_alu_if.sv
// Request/response bus between the sm83 execute stage and sm83_slice_alu.
// The master issues start/op/operands; the slave answers with ready/res/f_out/done.
interface sm83_slice_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] arg;
    logic [3:0]       flags_in;
    logic [WIDTH-1:0] res;
    logic [3:0]       f_out;
    logic             done;

    modport master (
        output start, op, acc, arg, flags_in,
        input  ready, res, f_out, done
    );

    modport slave (
        input  start, op, acc, arg, flags_in,
        output ready, res, f_out, done
    );
endinterface

// File: rtl/sm83_slice_alu.sv
// Slice-serial sm83 ALU/shift unit: arithmetic/logic LSB-first in WIDTH/SLICE cycles, shifts in one.
// Defining SM83_ALU_DAA_EN builds DAA as op 16 (WIDTH must be 8); otherwise op 16 is illegal.
module sm83_slice_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4,
    parameter int unsigned HBIT  = 4
) (
    input logic             clk,
    input logic             rst,
    sm83_slice_alu_if.slave bus
);
    localparam int unsigned NSL  = WIDTH / SLICE;
    localparam int unsigned CW   = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int          HSL  = int'(HBIT / SLICE) - 1;
    localparam int unsigned HALF = WIDTH / 2;

    if ((WIDTH % SLICE) != 0 || (HBIT % SLICE) != 0 || HBIT == 0 || HBIT >= WIDTH) begin : g_param_err
        $error("sm83_slice_alu: illegal WIDTH/SLICE/HBIT combination");
    end
`ifdef SM83_ALU_DAA_EN
    if (WIDTH != 8) begin : g_daa_err
        $error("sm83_slice_alu: DAA requires WIDTH == 8");
    end
`endif

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           r_state;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_res;
    logic [3:0]       r_f_out;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_z;
    logic             r_h;

    logic             w_accept;
    logic             w_serial;
    logic             w_step;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [CW-1:0]    w_k;
    logic             w_cin;
    logic             w_z_in;
    logic             w_h_in;
    logic             w_sub;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_slice_res;
    logic             w_z_new;
    logic             w_h_new;
    logic             w_last;
    logic [WIDTH-1:0] w_res_ext;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [3:0]       w_ser_f;
    logic [WIDTH-1:0] w_sc_res;
    logic [3:0]       w_sc_f;
    logic             w_sc_c;
    logic             w_sc_shift;

    assign w_accept = bus.start & r_ready;
    assign w_serial = (bus.op[4:3] == 2'b00);
    assign w_step   = (r_state == StRun) || (w_accept && w_serial);

    // Slice 0 is taken straight from the bus on the accept edge; later slices from the shifters.
    always_comb begin
        w_op   = r_op;
        w_a    = r_a;
        w_b    = r_b;
        w_k    = r_cnt;
        w_cin  = r_carry;
        w_z_in = r_z;
        w_h_in = r_h;
        if (w_accept) begin
            w_op   = bus.op[2:0];
            w_a    = bus.acc;
            w_b    = bus.arg;
            w_k    = '0;
            w_z_in = 1'b1;
            w_h_in = 1'b0;
            case (bus.op[2:0])
                3'd1:       w_cin = bus.flags_in[0];
                3'd2, 3'd7: w_cin = 1'b1;
                3'd3:       w_cin = ~bus.flags_in[0];
                default:    w_cin = 1'b0;
            endcase
        end
    end

    assign w_sub = (w_op == 3'd2) || (w_op == 3'd3) || (w_op == 3'd7);
    assign w_sa  = w_a[SLICE-1:0];
    assign w_sb  = w_sub ? ~w_b[SLICE-1:0] : w_b[SLICE-1:0];
    assign w_sum = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, w_cin};

    always_comb begin
        case (w_op)
            3'd4:    w_slice_res = w_sa & w_b[SLICE-1:0];
            3'd5:    w_slice_res = w_sa ^ w_b[SLICE-1:0];
            3'd6:    w_slice_res = w_sa | w_b[SLICE-1:0];
            3'd7:    w_slice_res = w_sa;
            default: w_slice_res = w_sum[SLICE-1:0];
        endcase
    end

    // CP shifts acc back into the result register but takes Z from the difference.
    assign w_z_new   = w_z_in & ~|((w_op == 3'd7) ? w_sum[SLICE-1:0] : w_slice_res);
    assign w_h_new   = (w_k == CW'(HSL)) ? w_sum[SLICE] : w_h_in;
    assign w_last    = (w_k == CW'(NSL - 1));
    assign w_res_ext = WIDTH'(w_slice_res);
    assign w_a_next  = (w_a >> SLICE) | (w_res_ext << (WIDTH - SLICE));
    assign w_b_next  = w_b >> SLICE;

    always_comb begin
        case (w_op)
            3'd4:       w_ser_f = {w_z_new, 3'b010};
            3'd5, 3'd6: w_ser_f = {w_z_new, 3'b000};
            default:    w_ser_f = {w_z_new, w_sub, w_h_new ^ w_sub, w_sum[SLICE] ^ w_sub};
        endcase
    end

`ifdef SM83_ALU_DAA_EN
    logic [7:0] w_daa_res;
    logic       w_daa_c;

    always_comb begin
        w_daa_res = bus.acc[7:0];
        w_daa_c   = bus.flags_in[0];
        if (!bus.flags_in[2]) begin
            if (bus.flags_in[0] || bus.acc[7:0] > 8'h99) begin
                w_daa_res = w_daa_res + 8'h60;
                w_daa_c   = 1'b1;
            end
            if (bus.flags_in[1] || bus.acc[3:0] > 4'd9) w_daa_res = w_daa_res + 8'h06;
        end else begin
            if (bus.flags_in[0]) w_daa_res = w_daa_res - 8'h60;
            if (bus.flags_in[1]) w_daa_res = w_daa_res - 8'h06;
        end
    end
`endif

    always_comb begin
        w_sc_res   = bus.acc;
        w_sc_f     = bus.flags_in;
        w_sc_c     = 1'b0;
        w_sc_shift = 1'b1;
        case (bus.op)
            5'd8: begin
                w_sc_res = {bus.acc[WIDTH-2:0], bus.flags_in[0]};
                w_sc_c   = bus.acc[WIDTH-1];
            end
            5'd9: begin
                w_sc_res = {bus.flags_in[0], bus.acc[WIDTH-1:1]};
                w_sc_c   = bus.acc[0];
            end
            5'd10: begin
                w_sc_res = {bus.acc[WIDTH-2:0], bus.acc[WIDTH-1]};
                w_sc_c   = bus.acc[WIDTH-1];
            end
            5'd11: begin
                w_sc_res = {bus.acc[0], bus.acc[WIDTH-1:1]};
                w_sc_c   = bus.acc[0];
            end
            5'd12: begin
                w_sc_res = {bus.acc[WIDTH-2:0], 1'b0};
                w_sc_c   = bus.acc[WIDTH-1];
            end
            5'd13: begin
                w_sc_res = {bus.acc[WIDTH-1], bus.acc[WIDTH-1:1]};
                w_sc_c   = bus.acc[0];
            end
            5'd14: begin
                w_sc_res = {1'b0, bus.acc[WIDTH-1:1]};
                w_sc_c   = bus.acc[0];
            end
            5'd15: w_sc_res = {bus.acc[HALF-1:0], bus.acc[WIDTH-1:HALF]};
`ifdef SM83_ALU_DAA_EN
            5'd16: begin
                w_sc_res   = WIDTH'(w_daa_res);
                w_sc_f     = {w_daa_res == 8'h00, bus.flags_in[2], 1'b0, w_daa_c};
                w_sc_shift = 1'b0;
            end
`endif
            default: w_sc_shift = 1'b0;
        endcase
        if (w_sc_shift) w_sc_f = {~|w_sc_res, 2'b00, w_sc_c};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_f_out <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_z     <= 1'b0;
            r_h     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_step) begin
                r_a     <= w_a_next;
                r_b     <= w_b_next;
                r_op    <= w_op;
                r_cnt   <= w_k + 1'b1;
                r_carry <= w_sum[SLICE];
                r_z     <= w_z_new;
                r_h     <= w_h_new;
            end
            unique case (r_state)
                StRun: begin
                    if (w_last) begin
                        r_res   <= w_a_next;
                        r_f_out <= w_ser_f;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= StFin;
                    end
                end
                StIdle, StFin: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (!w_serial) begin
                            r_res   <= w_sc_res;
                            r_f_out <= w_sc_f;
                            r_done  <= 1'b1;
                            r_state <= StFin;
                        end else if (w_last) begin
                            r_res   <= w_a_next;
                            r_f_out <= w_ser_f;
                            r_done  <= 1'b1;
                            r_state <= StFin;
                        end else begin
                            r_ready <= 1'b0;
                            r_state <= StRun;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.res   = r_res;
    assign bus.f_out = r_f_out;
endmodule

// File: tb/tb_sm83_slice_alu.sv
// Bench for sm83_slice_alu: vector table through a scoreboard, plus hand-written
// back-to-back, reset-abort, WIDTH=16 and hold sequences.
module tb_sm83_slice_alu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm83_slice_alu_if #(.WIDTH(8))  bus8 ();
    sm83_slice_alu_if #(.WIDTH(16)) bus16 ();

    sm83_slice_alu #(.WIDTH(8), .SLICE(4), .HBIT(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    sm83_slice_alu #(.WIDTH(16), .SLICE(4), .HBIT(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fi;
        logic [7:0] res;
        logic [3:0] fo;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [3:0] f;
        int         cyc;
        string      name;
    } exp_t;

    vec_t vecs[22];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && bus8.done) begin
            if (exp_q.size() == 0) begin
                check("done_without_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_res"}, 32'(bus8.res), 32'(e.res));
                check({e.name, "_flags"}, 32'(bus8.f_out), 32'(e.f));
                check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input string name, input vec_t v);
        int guard;
        int lat;
        guard = 0;
        lat = (v.op < 5'd8) ? 2 : 1;
        @(negedge clk);
        while (!bus8.ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready_before"}, 32'(bus8.ready), 32'd1);
        bus8.op       = v.op;
        bus8.acc      = v.a;
        bus8.arg      = v.b;
        bus8.flags_in = v.fi;
        bus8.start    = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{v.res, v.fo, cyc + lat - 1, name});
        bus8.start    = 1'b0;
        bus8.acc      = ~v.a;
        bus8.arg      = ~v.b;
        bus8.flags_in = ~v.fi;
        if (lat > 1) check({name, "_busy"}, 32'(bus8.ready), 32'd0);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !bus8.ready) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   lat16;
        logic got16;

        vecs[0]  = '{5'd0,  8'h3A, 8'hC6, 4'b0000, 8'h00, 4'b1011};
        vecs[1]  = '{5'd2,  8'h10, 8'h01, 4'b0000, 8'h0F, 4'b0110};
        vecs[2]  = '{5'd3,  8'h00, 8'h00, 4'b0001, 8'hFF, 4'b0111};
        vecs[3]  = '{5'd7,  8'h42, 8'h42, 4'b0000, 8'h42, 4'b1100};
        vecs[4]  = '{5'd4,  8'hF0, 8'h0F, 4'b0000, 8'h00, 4'b1010};
        vecs[5]  = '{5'd1,  8'h0F, 8'h00, 4'b0001, 8'h10, 4'b0010};
        vecs[6]  = '{5'd6,  8'h50, 8'h0A, 4'b0000, 8'h5A, 4'b0000};
        vecs[7]  = '{5'd5,  8'hAA, 8'hAA, 4'b0000, 8'h00, 4'b1000};
        vecs[8]  = '{5'd9,  8'h01, 8'h00, 4'b0001, 8'h80, 4'b0001};
        vecs[9]  = '{5'd10, 8'h85, 8'h00, 4'b0000, 8'h0B, 4'b0001};
        vecs[10] = '{5'd11, 8'h01, 8'h00, 4'b0000, 8'h80, 4'b0001};
        vecs[11] = '{5'd12, 8'h80, 8'h00, 4'b0000, 8'h00, 4'b1001};
        vecs[12] = '{5'd13, 8'h81, 8'h00, 4'b0000, 8'hC0, 4'b0001};
        vecs[13] = '{5'd14, 8'h01, 8'h00, 4'b0000, 8'h00, 4'b1001};
        vecs[14] = '{5'd15, 8'hF1, 8'h00, 4'b1111, 8'h1F, 4'b0000};
        vecs[15] = '{5'd17, 8'h5C, 8'h33, 4'b1010, 8'h5C, 4'b1010};
        vecs[16] = '{5'd2,  8'h3E, 8'h0F, 4'b0000, 8'h2F, 4'b0110};
        vecs[17] = '{5'd3,  8'h3B, 8'h2A, 4'b0001, 8'h10, 4'b0100};
        vecs[18] = '{5'd0,  8'hFF, 8'h01, 4'b0001, 8'h00, 4'b1011};
`ifdef SM83_ALU_DAA_EN
        vecs[19] = '{5'd16, 8'h9A, 8'h00, 4'b0000, 8'h00, 4'b1001};
`else
        vecs[19] = '{5'd16, 8'h9A, 8'h00, 4'b0000, 8'h9A, 4'b0000};
`endif
        vecs[20] = '{5'd8,  8'h40, 8'h00, 4'b0001, 8'h81, 4'b0000};
        vecs[21] = '{5'd31, 8'h00, 8'h00, 4'b0101, 8'h00, 4'b0101};

        bus8.start = 1'b0;   bus8.op = '0;   bus8.acc = '0;   bus8.arg = '0;   bus8.flags_in = '0;
        bus16.start = 1'b0;  bus16.op = '0;  bus16.acc = '0;  bus16.arg = '0;  bus16.flags_in = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(bus8.ready), 32'd1);
        check("reset_done", 32'(bus8.done), 32'd0);
        check("reset_res", 32'(bus8.res), 32'd0);
        check("reset_flags", 32'(bus8.f_out), 32'd0);
        check("reset_ready16", 32'(bus16.ready), 32'd1);

        for (int i = 0; i < 22; i++) issue($sformatf("vec%0d", i), vecs[i]);
        drain("table");

        // Result and flags must stay put while idle.
        issue("hold_sub", vecs[1]);
        drain("hold");
        repeat (3) @(negedge clk);
        check("hold_res", 32'(bus8.res), 32'h0F);
        check("hold_flags", 32'(bus8.f_out), 32'b0110);

        // Back-to-back: start stays high; RL is ignored while busy and accepted in the XOR done cycle.
        @(negedge clk);
        bus8.op = 5'd5;  bus8.acc = 8'hFF;  bus8.arg = 8'h0F;  bus8.flags_in = 4'b0000;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{8'hF0, 4'b0000, cyc + 1, "b2b_xor"});
        exp_q.push_back('{8'h00, 4'b1001, cyc + 2, "b2b_rl"});
        bus8.op = 5'd8;  bus8.acc = 8'h80;  bus8.arg = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        drain("b2b");

        // Reset one cycle after accepting ADD: the op is dropped with no done pulse.
        @(negedge clk);
        bus8.op = 5'd0;  bus8.acc = 8'h3A;  bus8.arg = 8'hC6;  bus8.flags_in = 4'b0000;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_ready", 32'(bus8.ready), 32'd1);
        check("abort_res", 32'(bus8.res), 32'd0);
        check("abort_flags", 32'(bus8.f_out), 32'd0);
        repeat (4) @(negedge clk);
        issue("rerun_add", vecs[0]);
        drain("rerun");

        // WIDTH=16: four slices, so done arrives in the fourth cycle after accept.
        @(negedge clk);
        bus16.op = 5'd0;  bus16.acc = 16'hFFFF;  bus16.arg = 16'h0001;  bus16.flags_in = 4'b0000;
        bus16.start = 1'b1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.acc = 16'h1234;
        lat16 = 0;
        got16 = 1'b0;
        for (int n = 1; n <= 10 && !got16; n++) begin
            @(negedge clk);
            if (bus16.done) begin
                got16 = 1'b1;
                lat16 = n;
            end
        end
        check("w16_latency", 32'(lat16), 32'd4);
        check("w16_res", 32'(bus16.res), 32'h0000);
        check("w16_flags", 32'(bus16.f_out), 32'b1011);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
